ifetch_queue: RTL and testbench

//  Instruction-fetch front end that drives the synchronous instruction-ROM read port (imem_en/imem_addr -> imem_data).
//  The ROM returns data one cycle after a request. Returned words are buffered with their PC in a small FIFO.
//  The FIFO feeds decode through a valid/ready handshake. Taken branches and jumps redirect fetch and flush all buffered and in-flight words.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/ifetch_queue_if.sv | 20 ++
 rtl/fetch_fifo.sv | 40 ++++
 rtl/ifetch_queue.sv | 61 ++++++
 tb/tb_ifetch_queue.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
package fetch_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;
   localparam logic [31:0] INSN_NOP = 32'h0000_0013;
   localparam int PC_STEP = 4;
endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_if: ROM read port, redirect input and decode handshake of the fetch queue.
interface ifetch_if;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_insn;
   modport master (
      output imem_en, imem_addr, out_valid, out_pc, out_insn,
      input  imem_data, redirect_valid, redirect_pc, out_ready
   );
   modport slave (
      input  imem_en, imem_addr, out_valid, out_pc, out_insn,
      output imem_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetched {pc, insn} entries; flush beats push.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  data,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);
   logic [AW-1:0] rd;
   logic [AW-1:0] wr;
   fetch_entry_t  mem [DEPTH];
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + AW'(1);
         if (pop) rd <= rd + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wr] <= data;
      end
   end
   assign head = mem[rd];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch front end issuing ROM reads and buffering returned words for decode.
module ifetch_queue
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic       clk,
   input logic       reset,
   ifetch_if.master  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;
   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          pop;
   logic          push;
   logic [CW-1:0] count;
   logic [OW-1:0] occupancy;
   fetch_entry_t  head;
   fetch_entry_t  push_data;
   // A pop this cycle frees a slot for the word returning next cycle, so issue counts it as credit.
   always_comb begin
      bus.out_valid = !reset && count != '0;
      pop           = bus.out_valid && bus.out_ready;
      push          = inflight && !bus.redirect_valid;
      occupancy     = OW'(count) + OW'(inflight) - OW'(pop);
      bus.imem_en   = !reset && !bus.redirect_valid && occupancy < OW'(DEPTH);
      bus.imem_addr = fetch_pc;
      bus.out_pc    = reset ? '0 : head.pc;
      bus.out_insn  = reset ? '0 : head.insn;
      push_data     = '{pc: inflight_pc, insn: bus.imem_data};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc <= bus.redirect_pc & ~32'h3;
         inflight <= 1'b0;
      end else begin
         inflight <= bus.imem_en;
         if (bus.imem_en) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'(PC_STEP);
         end
      end
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .data  (push_data),
      .count (count),
      .head  (head)
   );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and random-ready checks of the fetch queue against a golden PC stream.
module tb_ifetch_queue;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] exp_pc = '0;
   int          tests = 0;
   int          fails = 0;
   int          pops = 0;
   logic [31:0] last_pc;
   logic [31:0] wrap_pcs [3];
   ifetch_if bus ();
   ifetch_queue #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   // ROM word at address a is a>>2; garbage when not requested so stray sampling shows up.
   always_ff @(posedge clk)
      bus.imem_data <= bus.imem_en ? {2'b00, bus.imem_addr[31:2]} : 32'hDEAD_BEEF;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
      if (bus.out_valid && rdy) begin
         check("sb_pc", bus.out_pc, exp_pc);
         check("sb_insn", bus.out_insn, {2'b00, exp_pc[31:2]});
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (rv) exp_pc = rpc & ~32'h3;
      check("cnt_le_depth", 32'(dut.u_fifo.count <= 2), 32'd1);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      wrap_pcs[0] = 32'hFFFF_FFF8;
      wrap_pcs[1] = 32'hFFFF_FFFC;
      wrap_pcs[2] = 32'h0000_0000;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_en", 32'(bus.imem_en), 32'd0);
      check("rst_pc", bus.out_pc, 32'd0);
      check("rst_insn", bus.out_insn, 32'd0);
      // Test 1: streaming from reset, one word per cycle from T+2.
      reset = 1'b0;
      drive(1, 0, 0);
      check("t1_en_T", 32'(bus.imem_en), 32'd1);
      check("t1_addr_T", bus.imem_addr, 32'd0);
      check("t1_valid_T", 32'(bus.out_valid), 32'd0);
      step();
      drive(1, 0, 0);
      check("t1_addr_T1", bus.imem_addr, 32'd4);
      check("t1_valid_T1", 32'(bus.out_valid), 32'd0);
      step();
      for (int k = 2; k < 10; k++) begin
         drive(1, 0, 0);
         check("t1_valid", 32'(bus.out_valid), 32'd1);
         check("t1_en", 32'(bus.imem_en), 32'd1);
         check("t1_addr", bus.imem_addr, 32'(4 * k));
         step();
      end
      // Test 2: stall, FIFO fills, issue stops, head holds.
      last_pc = exp_pc;
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 0);
         check("t2_en", 32'(bus.imem_en), 32'd0);
         check("t2_valid", 32'(bus.out_valid), 32'd1);
         check("t2_pc_hold", bus.out_pc, last_pc);
         check("t2_insn_hold", bus.out_insn, {2'b00, last_pc[31:2]});
         step();
      end
      check("t2_full", 32'(dut.u_fifo.count), 32'd2);
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 0);
         step();
      end
      // Test 3: redirect with a non-empty FIFO and a word in flight.
      drive(0, 0, 0);
      step();
      drive(0, 0, 0);
      step();
      drive(1, 0, 0);
      step();
      drive(0, 1, 32'h0000_0103);
      check("t3_en_R", 32'(bus.imem_en), 32'd0);
      check("t3_valid_R", 32'(bus.out_valid), 32'd1);
      step();
      drive(1, 0, 0);
      check("t3_valid_R1", 32'(bus.out_valid), 32'd0);
      check("t3_en_R1", 32'(bus.imem_en), 32'd1);
      check("t3_addr_R1", bus.imem_addr, 32'h100);
      step();
      drive(1, 0, 0);
      check("t3_valid_R2", 32'(bus.out_valid), 32'd0);
      step();
      check("t3_valid_R3", 32'(bus.out_valid), 32'd1);
      check("t3_pc_R3", bus.out_pc, 32'h100);
      drive(1, 0, 0);
      step();
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 0);
         step();
      end
      // Test 4: back-to-back redirects; only the second stream is fetched.
      drive(1, 1, 32'h40);
      check("t4_en_R", 32'(bus.imem_en), 32'd0);
      step();
      drive(1, 1, 32'h80);
      check("t4_en_R1", 32'(bus.imem_en), 32'd0);
      check("t4_valid_R1", 32'(bus.out_valid), 32'd0);
      step();
      drive(1, 0, 0);
      check("t4_addr_R2", bus.imem_addr, 32'h80);
      step();
      drive(1, 0, 0);
      check("t4_addr_R3", bus.imem_addr, 32'h84);
      check("t4_valid_R3", 32'(bus.out_valid), 32'd0);
      step();
      drive(1, 0, 0);
      check("t4_valid_R4", 32'(bus.out_valid), 32'd1);
      step();
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0);
         step();
      end
      // Test 5: fetch_pc wraps past 32'hFFFF_FFFC.
      drive(1, 1, 32'hFFFF_FFF8);
      step();
      drive(1, 0, 0);
      step();
      drive(1, 0, 0);
      step();
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0);
         check("t5_valid", 32'(bus.out_valid), 32'd1);
         check("t5_wrap_pc", bus.out_pc, wrap_pcs[k]);
         step();
      end
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 0);
         step();
      end
      // Test 6: reset right after an issue drops the in-flight word.
      reset = 1'b1;
      drive(1, 0, 0);
      check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t6_rst_en", 32'(bus.imem_en), 32'd0);
      check("t6_rst_pc", bus.out_pc, 32'd0);
      check("t6_rst_insn", bus.out_insn, 32'd0);
      step();
      reset = 1'b0;
      exp_pc = 32'd0;
      drive(1, 0, 0);
      check("t6_en_T", 32'(bus.imem_en), 32'd1);
      check("t6_addr_T", bus.imem_addr, 32'd0);
      check("t6_valid_T", 32'(bus.out_valid), 32'd0);
      step();
      drive(1, 0, 0);
      check("t6_valid_T1", 32'(bus.out_valid), 32'd0);
      step();
      check("t6_valid_T2", 32'(bus.out_valid), 32'd1);
      check("t6_pc_T2", bus.out_pc, 32'd0);
      pops = 0;
      for (int k = 0; k < 10000; k++) begin
         drive(1'($urandom_range(0, 1)), 0, 0);
         step();
      end
      check("rand_pops", 32'(pops >= 2000), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
